// File: rtl/input_block_former.sv
`default_nettype none
// ============================================================================
// Module  : input_block_former
// Brief   : Pairs raster line rows through an even-row line buffer and emits
//           2x8x3 coding blocks over valid/ready. Optional chroma
//           downsampling when INPUT_BLOCK_CHROMA_SS_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module input_block_former #(
  parameter int MAX_SLICE_WIDTH = 2560,
  parameter int FIFO_DEPTH      = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               sof,
  input  logic [$clog2(MAX_SLICE_WIDTH)-1:0] slice_width,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [4*3*14-1:0]                  in_data_p,
  output logic                               blk_valid,
  input  logic                               blk_ready,
  output logic [2*8*3*14-1:0]                blk_p,
  output logic                               blk_sof
`ifdef INPUT_BLOCK_CHROMA_SS_EN
  ,
  input  logic [1:0]                         chroma_format
`endif
);

  localparam int WW     = $clog2(MAX_SLICE_WIDTH);
  localparam int DEPTH  = MAX_SLICE_WIDTH / 4;
  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = 14;
  localparam int PIX_W  = 3 * PW;
  localparam int BEAT_W = 4 * PIX_W;
  localparam int BLK_W  = 2 * 8 * 3 * PW;
  localparam int PTRW   = $clog2(FIFO_DEPTH);
  localparam int CW     = $clog2(FIFO_DEPTH + 1);

  logic [WW-1:0]     width_q;
  logic [AW-1:0]     beat_q, beat_d;
  logic              odd_q, odd_d;
  logic              sof_pend_q;
  logic [BEAT_W-1:0] lbuf [DEPTH];
  logic [BEAT_W-1:0] rd_q;
  logic              s1_valid_q, s1_lo_q, s1_done_q;
  logic [BEAT_W-1:0] s1_pix_q;
  logic [BEAT_W-1:0] half_r0_q, half_r1_q;
  logic [BLK_W:0]    fifo_q [FIFO_DEPTH];
  logic [PTRW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;

  logic              w_clr, w_accept, w_last, w_asm_push, w_push, w_pop;
  logic [AW-1:0]     w_beats;
  logic [2:0]        w_inflight, w_occ;
  logic [BEAT_W-1:0] w_r0_lo, w_r1_lo, w_r0_hi, w_r1_hi;
  logic [BLK_W-1:0]  w_blk, w_push_blk;
  logic [BLK_W:0]    w_head;

  assign w_clr      = sof | flush;
  assign w_beats    = AW'(width_q >> 2);
  assign w_last     = (beat_q == w_beats - AW'(1));
  assign w_asm_push = s1_valid_q & s1_done_q;
  assign w_occ      = 3'(count_q) + w_inflight;
  assign in_ready   = ~w_clr & (w_occ < 3'(FIFO_DEPTH));
  assign w_accept   = in_valid & in_ready;

  always_comb begin
    beat_d = beat_q;
    odd_d  = odd_q;
    if (w_clr) begin
      beat_d = '0;
      odd_d  = 1'b0;
    end else if (w_accept) begin
      if (w_last) begin
        beat_d = '0;
        odd_d  = ~odd_q;
      end else begin
        beat_d = beat_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q    <= '0;
      beat_q     <= '0;
      odd_q      <= 1'b0;
      sof_pend_q <= 1'b0;
    end else begin
      beat_q <= beat_d;
      odd_q  <= odd_d;
      if (sof && !flush) width_q <= slice_width;
      if (flush)       sof_pend_q <= 1'b0;
      else if (sof)    sof_pend_q <= 1'b1;
      else if (w_push) sof_pend_q <= 1'b0;
    end
  end

  // Even rows fill the line buffer; odd rows read the matching word back.
  always_ff @(posedge clk) begin
    if (w_accept && !odd_q) lbuf[beat_q] <= in_data_p;
    if (w_accept && odd_q)  rd_q <= lbuf[beat_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_lo_q    <= 1'b0;
      s1_done_q  <= 1'b0;
      s1_pix_q   <= '0;
      half_r0_q  <= '0;
      half_r1_q  <= '0;
    end else if (w_clr) begin
      s1_valid_q <= 1'b0;
      half_r0_q  <= '0;
      half_r1_q  <= '0;
    end else begin
      s1_valid_q <= w_accept & odd_q;
      if (w_accept) begin
        s1_lo_q   <= ~beat_q[0];
        s1_done_q <= beat_q[0] | w_last;
        s1_pix_q  <= in_data_p;
      end
      if (s1_valid_q && s1_lo_q) begin
        half_r0_q <= rd_q;
        half_r1_q <= s1_pix_q;
      end
    end
  end

  // A left half that completes a block is padded by repeating its column 3.
  assign w_r0_lo = s1_lo_q ? rd_q     : half_r0_q;
  assign w_r1_lo = s1_lo_q ? s1_pix_q : half_r1_q;
  assign w_r0_hi = s1_lo_q ? {4{rd_q[3*PIX_W +: PIX_W]}}     : rd_q;
  assign w_r1_hi = s1_lo_q ? {4{s1_pix_q[3*PIX_W +: PIX_W]}} : s1_pix_q;

  always_comb begin
    w_blk = '0;
    for (int cp = 0; cp < 3; cp++) begin
      for (int c = 0; c < 4; c++) begin
        w_blk[(cp*16 + c)*PW      +: PW] = w_r0_lo[(c*3 + cp)*PW +: PW];
        w_blk[(cp*16 + 4 + c)*PW  +: PW] = w_r0_hi[(c*3 + cp)*PW +: PW];
        w_blk[(cp*16 + 8 + c)*PW  +: PW] = w_r1_lo[(c*3 + cp)*PW +: PW];
        w_blk[(cp*16 + 12 + c)*PW +: PW] = w_r1_hi[(c*3 + cp)*PW +: PW];
      end
    end
  end

`ifdef INPUT_BLOCK_CHROMA_SS_EN
  logic [1:0]       fmt_q;
  logic             s2_valid_q;
  logic [BLK_W-1:0] s2_blk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fmt_q      <= 2'd0;
      s2_valid_q <= 1'b0;
      s2_blk_q   <= '0;
    end else begin
      if (sof && !flush) fmt_q <= chroma_format;
      s2_valid_q <= w_clr ? 1'b0 : w_asm_push;
      if (w_asm_push) s2_blk_q <= w_blk;
    end
  end

  always_comb begin : chroma_ds
    logic [PW:0]   w_pr0, w_pr1;
    logic [PW+1:0] w_quad;
    w_push_blk = s2_blk_q;
    w_pr0      = '0;
    w_pr1      = '0;
    w_quad     = '0;
    if (fmt_q == 2'd1 || fmt_q == 2'd2) begin
      for (int cp = 1; cp < 3; cp++) begin
        for (int k = 0; k < 4; k++) begin
          w_pr0  = {1'b0, s2_blk_q[(cp*16 + 2*k)*PW +: PW]}
                 + {1'b0, s2_blk_q[(cp*16 + 2*k + 1)*PW +: PW]};
          w_pr1  = {1'b0, s2_blk_q[(cp*16 + 8 + 2*k)*PW +: PW]}
                 + {1'b0, s2_blk_q[(cp*16 + 8 + 2*k + 1)*PW +: PW]};
          w_quad = {1'b0, w_pr0} + {1'b0, w_pr1} + (PW+2)'(2);
          w_pr0  = w_pr0 + (PW+1)'(1);
          w_pr1  = w_pr1 + (PW+1)'(1);
          w_push_blk[(cp*16 + k)*PW      +: PW] = (fmt_q == 2'd2) ? w_quad[PW+1:2] : w_pr0[PW:1];
          w_push_blk[(cp*16 + 8 + k)*PW  +: PW] = (fmt_q == 2'd2) ? '0 : w_pr1[PW:1];
          w_push_blk[(cp*16 + 4 + k)*PW  +: PW] = '0;
          w_push_blk[(cp*16 + 12 + k)*PW +: PW] = '0;
        end
      end
    end
  end

  assign w_push     = s2_valid_q;
  assign w_inflight = 3'(w_asm_push) + 3'(s2_valid_q);
`else
  assign w_push     = w_asm_push;
  assign w_push_blk = w_blk;
  assign w_inflight = 3'(w_asm_push);
`endif

  assign w_head    = fifo_q[rd_ptr_q];
  assign blk_valid = (count_q != '0);
  assign blk_p     = blk_valid ? w_head[BLK_W-1:0] : '0;
  assign blk_sof   = blk_valid & w_head[BLK_W];
  assign w_pop     = blk_valid & blk_ready;

  always_ff @(posedge clk) begin
    if (w_push && !w_clr) fifo_q[wr_ptr_q] <= {sof_pend_q, w_push_blk};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (w_clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + PTRW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + PTRW'(1);
      count_q <= count_q + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule
`default_nettype wire
